// File: rtl/ex1_b_pkg.sv
// Shared constants, FSM state type and select mapping for the ex1_b mux and its scan sequencer.
package ex1_b_pkg;

    localparam int unsigned NUM_CH = 5;
    localparam int unsigned SEL_W  = 3;
    localparam logic [SEL_W-1:0] CH_Y = 3'b100;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    // Channel indices above 4 never occur; they fold onto Y like the mux does.
    function automatic logic [SEL_W-1:0] ch_to_sel(input logic [SEL_W-1:0] ch);
        return (ch >= CH_Y) ? CH_Y : ch;
    endfunction

endpackage

// File: rtl/ex1_b.sv
// ex1_b: 5-to-1 DATA_WIDTH-bit channel mux, select {s2,s1,s0}: 000=U 001=V 010=W 011=X 1xx=Y.
module ex1_b #(
    parameter int unsigned DATA_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0] U,
    input  logic [DATA_WIDTH-1:0] V,
    input  logic [DATA_WIDTH-1:0] W,
    input  logic [DATA_WIDTH-1:0] X,
    input  logic [DATA_WIDTH-1:0] Y,
    input  logic                  s2,
    input  logic                  s1,
    input  logic                  s0,
    output logic [DATA_WIDTH-1:0] M
);

    always_comb begin
        M = Y;
        if (!s2) begin
            case ({s1, s0})
                2'b00:   M = U;
                2'b01:   M = V;
                2'b10:   M = W;
                default: M = X;
            endcase
        end
    end

endmodule

// File: rtl/ex1_b_dwell_cnt.sv
// Free-running DWELL-cycle counter for the scan sequencer; tc is high on the last cycle of a dwell.
module ex1_b_dwell_cnt #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 8'd1;
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == LAST);

endmodule

// File: rtl/ex1_b_scan_ctrl.sv
// Scan sequencer around the ex1_b mux: steps U..Y, samples M into a shadow, publishes a snapshot.
// Optional SCAN_PARITY_EN adds snap_par, the per-slot even parity of snap.
module ex1_b_scan_ctrl
    import ex1_b_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 3,
    parameter int unsigned DWELL      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         s2,
    output logic                         s1,
    output logic                         s0,
    input  logic [DATA_WIDTH-1:0]        M,
    output logic                         busy,
    output logic                         done,
`ifdef SCAN_PARITY_EN
    output logic [NUM_CH-1:0]            snap_par,
`endif
    output logic [NUM_CH*DATA_WIDTH-1:0] snap
);

    localparam int unsigned SNAP_W = NUM_CH * DATA_WIDTH;
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(NUM_CH - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   ch_q;
    logic [SEL_W-1:0]   sel_q;
    logic               busy_q;
    logic               done_q;
    logic [SNAP_W-1:0]  shadow_q;
    logic [SNAP_W-1:0]  snap_q;
    logic [SNAP_W-1:0]  shadow_upd;
    logic               tc;

    ex1_b_dwell_cnt #(
        .DWELL(DWELL)
    ) u_dwell_cnt (
        .clk(clk),
        .rst(rst),
        .clr(state_q != SCAN),
        .tc (tc)
    );

    // Shadow with the current slot replaced, so the last capture lands in snap on the same edge.
    always_comb begin
        shadow_upd = shadow_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == SEL_W'(i)) begin
                shadow_upd[i*DATA_WIDTH +: DATA_WIDTH] = M;
            end
        end
    end

`ifdef SCAN_PARITY_EN
    logic [NUM_CH-1:0] par_upd;
    logic [NUM_CH-1:0] snap_par_q;

    always_comb begin
        par_upd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            par_upd[i] = ^shadow_upd[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign snap_par = snap_par_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shadow_q <= '0;
            snap_q   <= '0;
`ifdef SCAN_PARITY_EN
            snap_par_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= SCAN;
                        ch_q    <= '0;
                        sel_q   <= ch_to_sel('0);
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (tc) begin
                        shadow_q <= shadow_upd;
                        if (ch_q == CH_LAST) begin
                            state_q <= DONE;
                            sel_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            snap_q  <= shadow_upd;
`ifdef SCAN_PARITY_EN
                            snap_par_q <= par_upd;
`endif
                        end else begin
                            ch_q  <= ch_q + 3'd1;
                            sel_q <= ch_to_sel(ch_q + 3'd1);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {s2, s1, s0} = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign snap         = snap_q;

endmodule

// File: tb/tb_ex1_b_scan_ctrl.sv
// Bench: ex1_b mux and ex1_b_scan_ctrl back to back, checked against a cycle-timeline model.
module tb_ex1_b_scan_ctrl;

    localparam int unsigned DW     = 3;
    localparam int unsigned DWELL  = 4;
    localparam int unsigned NCH    = 5;
    localparam int unsigned SNAP_W = NCH * DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DW-1:0]     ch_in [NCH];
    logic              s2, s1, s0;
    logic [DW-1:0]     m;
    logic              busy, done;
    logic [SNAP_W-1:0] snap;
`ifdef SCAN_PARITY_EN
    logic [NCH-1:0]    snap_par;
`endif

    int unsigned       n_checks = 0;
    int unsigned       n_fail   = 0;
    logic [SNAP_W-1:0] exp_snap = '0;

    always #5 clk = ~clk;

    ex1_b #(
        .DATA_WIDTH(DW)
    ) u_mux (
        .U (ch_in[0]),
        .V (ch_in[1]),
        .W (ch_in[2]),
        .X (ch_in[3]),
        .Y (ch_in[4]),
        .s2(s2),
        .s1(s1),
        .s0(s0),
        .M (m)
    );

    ex1_b_scan_ctrl #(
        .DATA_WIDTH(DW),
        .DWELL     (DWELL)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .s2   (s2),
        .s1   (s1),
        .s0   (s0),
        .M    (m),
        .busy (busy),
        .done (done),
`ifdef SCAN_PARITY_EN
        .snap_par(snap_par),
`endif
        .snap (snap)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NCH-1:0] parity_of(input logic [SNAP_W-1:0] s);
        logic [NCH-1:0] p;
        for (int i = 0; i < NCH; i++) begin
            p[i] = ^s[i*DW +: DW];
        end
        return p;
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, "_sel"}, 64'({s2, s1, s0}), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_done"}, 64'(done), 64'd0);
        check_eq({tag, "_snap"}, 64'(snap), 64'(exp_snap));
`ifdef SCAN_PARITY_EN
        check_eq({tag, "_par"}, 64'(snap_par), 64'(parity_of(exp_snap)));
`endif
    endtask

    // Fixed mode holds U..Y = 1..5 with a short U glitch away from its sample point.
    task automatic drive(input bit fixed, input int j);
        for (int i = 0; i < NCH; i++) begin
            ch_in[i] = fixed ? DW'(i + 1) : DW'($urandom);
        end
        if (fixed && j == 0) begin
            ch_in[0] = 3'd7;
        end
    endtask

    // Called at a negedge with the DUT idle; start is taken at the next posedge (edge k).
    task automatic run_scan(input bit fixed, input bit hold);
        logic [DW-1:0]     sampled [NCH];
        logic [SNAP_W-1:0] new_snap;
        start = 1'b1;
        drive(fixed, -1);
        @(posedge clk);
        for (int j = 0; j < int'(NCH * DWELL); j++) begin
            @(negedge clk);
            start = hold;
            check_eq("scan_busy", 64'(busy), 64'd1);
            check_eq("scan_sel", 64'({s2, s1, s0}), 64'(j / int'(DWELL)));
            check_eq("scan_done", 64'(done), 64'd0);
            check_eq("scan_snap_hold", 64'(snap), 64'(exp_snap));
            drive(fixed, j);
            // Values driven now are seen at edge k+j+1; every DWELL-th edge samples a channel.
            if ((j + 1) % int'(DWELL) == 0) begin
                sampled[(j + 1) / int'(DWELL) - 1] = ch_in[(j + 1) / int'(DWELL) - 1];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            new_snap[i*DW +: DW] = sampled[i];
        end
        exp_snap = new_snap;
        @(negedge clk);
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_busy", 64'(busy), 64'd0);
        check_eq("done_sel", 64'({s2, s1, s0}), 64'd0);
        check_eq("done_snap", 64'(snap), 64'(exp_snap));
`ifdef SCAN_PARITY_EN
        check_eq("done_par", 64'(snap_par), 64'(parity_of(exp_snap)));
`endif
        @(negedge clk);
        check_quiet("after_done");
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        drive(1'b0, -1);
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_quiet("post_reset");

        run_scan(1'b1, 1'b0);
        check_eq("basic_snap", 64'(snap), 64'(15'b101_100_011_010_001));
`ifdef SCAN_PARITY_EN
        check_eq("basic_par", 64'(snap_par), 64'(5'b01011));
`endif
        repeat (3) begin
            drive(1'b0, -1);
            @(negedge clk);
            check_quiet("idle_hold");
        end

        run_scan(1'b0, 1'b1);
        run_scan(1'b0, 1'b1);
        run_scan(1'b0, 1'b0);

        // Abort during channel W.
        start = 1'b1;
        drive(1'b0, -1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("mid_sel_w", 64'({s2, s1, s0}), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_snap = '0;
        check_quiet("mid_reset");

        for (int n = 0; n < 4; n++) begin
            run_scan(1'b0, 1'($urandom_range(0, 1)));
            start = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                check_quiet("gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
